// File: rtl/fx_match_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx_match_pkg
// Purpose  : Shared constants and helpers for the fixed-point format-match
//            scheduler and its quantize/overflow core.
// Revision : 1.0
// ============================================================================
package fx_match_pkg;

   localparam int RND_TRUNC   = 0;
   localparam int RND_HALF_UP = 1;
   localparam int OVF_WRAP    = 0;
   localparam int OVF_SAT     = 1;

   function automatic int fx_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] fx_sat_max(input int ow);
      return (64'sd1 <<< (ow - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] fx_sat_min(input int ow);
      return -(64'sd1 <<< (ow - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fx_match_core.sv
`default_nettype none
// ============================================================================
// Module   : fx_match_core
// Purpose  : Fixed-latency quantize + overflow pipeline carrying valid and
//            requester ID alongside the data; freezes completely on stall.
// Revision : 1.0
// ============================================================================
module fx_match_core
   import fx_match_pkg::*;
#(
   parameter int IW  = 13,
   parameter int IF  = 8,
   parameter int OW  = 14,
   parameter int OF  = 8,
   parameter int IDW = 2,
   parameter int LAT = 3,
   parameter int RND = RND_HALF_UP,
   parameter int SAT = OVF_SAT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_stall,
   input  logic           i_valid,
   input  logic [IW-1:0]  i_data,
   input  logic [IDW-1:0] i_id,
   output logic           o_valid,
   output logic [OW-1:0]  o_data,
   output logic [IDW-1:0] o_id,
   output logic           o_ovf
);

   localparam int D  = IF - OF;
   localparam int SH = (D > 0) ? D : 0;
   localparam int LS = (D < 0) ? -D : 0;
   // One spare MSB keeps the rounding carry of the most positive input.
   localparam int QW = IW + 1 + LS;
   localparam logic signed [QW-1:0] HALF =
      (SH > 0 && RND == RND_HALF_UP) ? (QW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
   localparam logic signed [63:0] SMAX = fx_sat_max(OW);
   localparam logic signed [63:0] SMIN = fx_sat_min(OW);

   function automatic logic signed [QW-1:0] quantize(input logic signed [IW-1:0] x);
      logic signed [QW-1:0] xe;
      xe = QW'(x);
      return ((xe + HALF) >>> SH) <<< LS;
   endfunction

   // Returns {overflow, result}.
   function automatic logic [OW:0] fit(input logic signed [QW-1:0] q);
      logic signed [63:0] qe;
      logic [OW-1:0]      d;
      logic               ov;
      qe = 64'(q);
      ov = 1'b0;
      d  = qe[OW-1:0];
      if (qe > SMAX) begin
         ov = 1'b1;
         if (SAT == OVF_SAT) d = SMAX[OW-1:0];
      end else if (qe < SMIN) begin
         ov = 1'b1;
         if (SAT == OVF_SAT) d = SMIN[OW-1:0];
      end
      return {ov, d};
   endfunction

   logic                 fin_valid;
   logic signed [QW-1:0] fin_q;
   logic [IDW-1:0]       fin_id;
   logic [OW:0]          fit_res;

   generate
      if (LAT == 1) begin : g_lat1
         assign fin_valid = i_valid;
         assign fin_q     = quantize(i_data);
         assign fin_id    = i_id;
      end else if (LAT == 2) begin : g_lat2
         logic           s0_valid_q;
         logic [IW-1:0]  s0_data_q;
         logic [IDW-1:0] s0_id_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               s0_valid_q <= 1'b0;
               s0_data_q  <= '0;
               s0_id_q    <= '0;
            end else if (!i_stall) begin
               s0_valid_q <= i_valid;
               s0_data_q  <= i_data;
               s0_id_q    <= i_id;
            end
         end

         assign fin_valid = s0_valid_q;
         assign fin_q     = quantize(s0_data_q);
         assign fin_id    = s0_id_q;
      end else begin : g_latn
         localparam int NQ = LAT - 2;
         logic                 s0_valid_q;
         logic [IW-1:0]        s0_data_q;
         logic [IDW-1:0]       s0_id_q;
         logic                 qv_q  [NQ];
         logic signed [QW-1:0] q_q   [NQ];
         logic [IDW-1:0]       qid_q [NQ];

         // Stage 0 captures the raw word; stage 1 holds the quantized value.
         always_ff @(posedge clk) begin
            if (rst) begin
               s0_valid_q <= 1'b0;
               s0_data_q  <= '0;
               s0_id_q    <= '0;
               for (int i = 0; i < NQ; i++) begin
                  qv_q[i]  <= 1'b0;
                  q_q[i]   <= '0;
                  qid_q[i] <= '0;
               end
            end else if (!i_stall) begin
               s0_valid_q <= i_valid;
               s0_data_q  <= i_data;
               s0_id_q    <= i_id;
               qv_q[0]    <= s0_valid_q;
               q_q[0]     <= quantize(s0_data_q);
               qid_q[0]   <= s0_id_q;
               for (int i = 1; i < NQ; i++) begin
                  qv_q[i]  <= qv_q[i-1];
                  q_q[i]   <= q_q[i-1];
                  qid_q[i] <= qid_q[i-1];
               end
            end
         end

         assign fin_valid = qv_q[NQ-1];
         assign fin_q     = q_q[NQ-1];
         assign fin_id    = qid_q[NQ-1];
      end
   endgenerate

   assign fit_res = fit(fin_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_id    <= '0;
         o_ovf   <= 1'b0;
      end else if (!i_stall) begin
         o_valid <= fin_valid;
         o_data  <= fit_res[OW-1:0];
         o_id    <= fin_id;
         o_ovf   <= fit_res[OW];
      end
   end

endmodule
`default_nettype wire

// File: rtl/fx_match_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fx_match_share_ctrl
// Purpose  : Round-robin sharing of one format-match pipeline among NREQ
//            requesters. Define FX_MATCH_OVF_CNT_EN to add per-requester
//            saturating overflow counters (o_ovf_cnt, i_ovf_clr).
// Revision : 1.0
// ============================================================================
module fx_match_share_ctrl
   import fx_match_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int IW   = 13,
   parameter  int IF   = 8,
   parameter  int OW   = 14,
   parameter  int OF   = 8,
   parameter  int LAT  = 3,
   parameter  int RND  = 1,
   parameter  int SAT  = 1,
   localparam int IDW  = fx_id_w(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FX_MATCH_OVF_CNT_EN
   input  logic                 i_ovf_clr,
   output logic [NREQ*16-1:0]   o_ovf_cnt,
`endif
   input  logic [NREQ-1:0]      i_valid,
   input  logic [NREQ*IW-1:0]   i_data,
   output logic [NREQ-1:0]      o_ready,
   input  logic                 i_stall,
   output logic                 o_valid,
   output logic [OW-1:0]        o_data,
   output logic [IDW-1:0]       o_id,
   output logic                 o_ovf
);

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  sel_id;
   logic [IDW:0]    scan;
   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [IW-1:0]   sel_data;

   // Scan from the pointer upward, wrapping at NREQ; first valid wins.
   always_comb begin
      grant  = '0;
      sel_id = '0;
      xfer   = 1'b0;
      scan   = '0;
      if (!i_stall) begin
         for (int o = 0; o < NREQ; o++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(o);
            if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
            if (!xfer && i_valid[scan[IDW-1:0]]) begin
               xfer                = 1'b1;
               grant[scan[IDW-1:0]] = 1'b1;
               sel_id              = scan[IDW-1:0];
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + IDW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign o_ready  = grant;
   assign sel_data = i_data[sel_id*IW +: IW];

   fx_match_core #(
      .IW  (IW),
      .IF  (IF),
      .OW  (OW),
      .OF  (OF),
      .IDW (IDW),
      .LAT (LAT),
      .RND (RND),
      .SAT (SAT)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .i_stall (i_stall),
      .i_valid (xfer),
      .i_data  (sel_data),
      .i_id    (sel_id),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_id    (o_id),
      .o_ovf   (o_ovf)
   );

`ifdef FX_MATCH_OVF_CNT_EN
   generate
      for (genvar k = 0; k < NREQ; k++) begin : g_cnt
         logic [15:0] cnt_q;
         // A held result counts once per unstalled cycle it is presented.
         always_ff @(posedge clk) begin
            if (rst || i_ovf_clr) begin
               cnt_q <= '0;
            end else if (!i_stall && o_valid && o_ovf && o_id == IDW'(k)
                         && cnt_q != 16'hFFFF) begin
               cnt_q <= cnt_q + 16'd1;
            end
         end
         assign o_ovf_cnt[k*16 +: 16] = cnt_q;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fx_match_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fx_match_share_ctrl
// Purpose  : Directed checks of arbitration, latency, stall, reset and the
//            quantize/overflow formats over five parameterisations.
// Revision : 1.0
// ============================================================================
module tb_fx_match_share_ctrl;

   localparam int NREQ = 4;
   localparam int IW   = 13;
   localparam int OW   = 14;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    i_valid;
   logic [NREQ*IW-1:0] i_data;
   logic               i_stall;

   logic [NREQ-1:0] rdy_id, rdy_rn, rdy_tr, rdy_sa, rdy_wr;
   logic            v_id, v_rn, v_tr, v_sa, v_wr;
   logic [OW-1:0]   d_id, d_rn, d_tr, d_sa, d_wr;
   logic [IDW-1:0]  id_id, id_rn, id_tr, id_sa, id_wr;
   logic            ov_id, ov_rn, ov_tr, ov_sa, ov_wr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fx_match_share_ctrl #(.IF(8), .OF(8), .RND(1), .SAT(1)) u_ident (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy_id),
      .i_stall(i_stall), .o_valid(v_id), .o_data(d_id), .o_id(id_id), .o_ovf(ov_id));
   fx_match_share_ctrl #(.IF(8), .OF(6), .RND(1), .SAT(1)) u_rnd (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy_rn),
      .i_stall(i_stall), .o_valid(v_rn), .o_data(d_rn), .o_id(id_rn), .o_ovf(ov_rn));
   fx_match_share_ctrl #(.IF(8), .OF(6), .RND(0), .SAT(1)) u_trc (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy_tr),
      .i_stall(i_stall), .o_valid(v_tr), .o_data(d_tr), .o_id(id_tr), .o_ovf(ov_tr));
   fx_match_share_ctrl #(.IF(4), .OF(8), .RND(1), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy_sa),
      .i_stall(i_stall), .o_valid(v_sa), .o_data(d_sa), .o_id(id_sa), .o_ovf(ov_sa));
   fx_match_share_ctrl #(.IF(4), .OF(8), .RND(1), .SAT(0)) u_wrp (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy_wr),
      .i_stall(i_stall), .o_valid(v_wr), .o_data(d_wr), .o_id(id_wr), .o_ovf(ov_wr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int gexp(input int n);
      return (n < 8) ? (n % 4) : 3;
   endfunction

   // Format vectors: input, identity, round(8->6), trunc(8->6), sat(4->8), wrap(4->8), ovf(4->8)
   logic [IW-1:0] vx    [7] = '{13'h1FFF, 13'h0006, 13'h0005, 13'h1FFE, 13'h0007, 13'h0FFF, 13'h1000};
   logic [OW-1:0] e_id  [7] = '{14'h3FFF, 14'h0006, 14'h0005, 14'h3FFE, 14'h0007, 14'h0FFF, 14'h3000};
   logic [OW-1:0] e_rn  [7] = '{14'h0000, 14'h0002, 14'h0001, 14'h0000, 14'h0002, 14'h0400, 14'h3C00};
   logic [OW-1:0] e_tr  [7] = '{14'h3FFF, 14'h0001, 14'h0001, 14'h3FFF, 14'h0001, 14'h03FF, 14'h3C00};
   logic [OW-1:0] e_sa  [7] = '{14'h3FF0, 14'h0060, 14'h0050, 14'h3FE0, 14'h0070, 14'h1FFF, 14'h2000};
   logic [OW-1:0] e_wr  [7] = '{14'h3FF0, 14'h0060, 14'h0050, 14'h3FE0, 14'h0070, 14'h3FF0, 14'h0000};
   logic          e_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst     = 1'b1;
      i_valid = '0;
      i_data  = '0;
      i_stall = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'({v_id, v_rn, v_tr, v_sa, v_wr}), 32'h0);
      chk("rst_data",  32'(d_id), 32'h0);
      chk("rst_id",    32'(id_id), 32'h0);
      chk("rst_ovf",   32'(ov_id), 32'h0);
      chk("rst_ready", 32'(rdy_id), 32'h0);
      rst = 1'b0;

      // Identity format, single request from requester 2, latency 3.
      i_valid = 4'b0100;
      i_data[2*IW +: IW] = 13'h1FFF;
      #1;
      chk("id_ready", 32'(rdy_id), 32'h4);
      tick();
      i_valid = '0;
      tick();
      chk("id_lat2_valid", 32'(v_id), 32'h0);
      tick();
      chk("id_valid", 32'(v_id), 32'h1);
      chk("id_data",  32'(d_id), 32'h3FFF);
      chk("id_id",    32'(id_id), 32'h2);
      chk("id_ovf",   32'(ov_id), 32'h0);

      // Back-to-back format vectors from requester 0 alone.
      for (int n = 0; n < 9; n++) begin
         if (n < 7) begin
            i_valid = 4'b0001;
            i_data  = '0;
            i_data[IW-1:0] = vx[n];
         end else begin
            i_valid = '0;
         end
         #1;
         if (n < 7) chk("tbl_ready", 32'({rdy_id, rdy_rn, rdy_tr, rdy_sa, rdy_wr}), 32'h11111);
         tick();
         if (n >= 2) begin
            chk("tbl_valid",  32'({v_id, v_rn, v_tr, v_sa, v_wr}), 32'h1F);
            chk("tbl_oid",    32'({id_id, id_rn, id_tr, id_sa, id_wr}), 32'h0);
            chk("tbl_ident",  32'(d_id), 32'(e_id[n-2]));
            chk("tbl_round",  32'(d_rn), 32'(e_rn[n-2]));
            chk("tbl_trunc",  32'(d_tr), 32'(e_tr[n-2]));
            chk("tbl_sat",    32'(d_sa), 32'(e_sa[n-2]));
            chk("tbl_wrap",   32'(d_wr), 32'(e_wr[n-2]));
            chk("tbl_ovf_lo", 32'({ov_id, ov_rn, ov_tr}), 32'h0);
            chk("tbl_ovf_sa", 32'(ov_sa), 32'(e_ov[n-2]));
            chk("tbl_ovf_wr", 32'(ov_wr), 32'(e_ov[n-2]));
         end
      end
      tick();
      chk("drain_valid", 32'({v_id, v_rn, v_tr, v_sa, v_wr}), 32'h0);

      // Reset mid-stream with two results in flight.
      i_valid = 4'b1111;
      i_data  = {13'd4, 13'd3, 13'd2, 13'd1};
      #1;
      chk("pre_rst_ready", 32'(rdy_id), 32'h2);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_rst_valid", 32'(v_id), 32'h0);
      chk("post_rst_ready", 32'(rdy_id), 32'h1);

      // Fairness: all valid for 8 grants, then requester 3 alone for 4.
      for (int n = 0; n < 14; n++) begin
         i_valid = (n < 8) ? 4'b1111 : ((n < 12) ? 4'b1000 : 4'b0000);
         #1;
         if (n < 12) chk("rr_ready", 32'(rdy_id), 32'(1 << gexp(n)));
         tick();
         if (n < 2) begin
            chk("rst_flush", 32'(v_id), 32'h0);
         end else begin
            chk("rr_valid", 32'(v_id), 32'h1);
            chk("rr_id",    32'(id_id), 32'(gexp(n-2)));
            chk("rr_data",  32'(d_id), 32'(gexp(n-2) + 1));
         end
      end
      i_valid = 4'b1111;
      #1;
      chk("ptr_wrap", 32'(rdy_id), 32'h1);

      // Stall with the pipeline full.
      tick();
      tick();
      tick();
      chk("fill_valid", 32'(v_id), 32'h1);
      chk("fill_id",    32'(id_id), 32'h0);
      i_stall = 1'b1;
      #1;
      chk("stall_ready", 32'(rdy_id), 32'h0);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("stall_ready_h", 32'(rdy_id), 32'h0);
         chk("stall_hold",    32'({v_id, id_id, d_id}), 32'({1'b1, 2'd0, 14'd1}));
      end
      i_stall = 1'b0;
      #1;
      chk("unstall_ready", 32'(rdy_id), 32'h8);
      tick();
      chk("resume0", 32'({v_id, id_id, d_id}), 32'({1'b1, 2'd1, 14'd2}));
      tick();
      chk("resume1", 32'({v_id, id_id, d_id}), 32'({1'b1, 2'd2, 14'd3}));
      i_valid = '0;
      tick();
      chk("resume2", 32'({v_id, id_id, d_id}), 32'({1'b1, 2'd3, 14'd4}));
      tick();
      chk("resume3", 32'({v_id, id_id, d_id}), 32'({1'b1, 2'd0, 14'd1}));
      tick();
      chk("resume_end", 32'(v_id), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fx_match_share_ctrl.md
Name: fx_match_share_ctrl

Overview:
Round-robin scheduler that time-multiplexes NREQ fixed-point requesters onto one shared format-match datapath. The datapath performs LSB quantization (round-half-up or truncate) and MSB overflow handling (saturate or sign-extend/wrap). Results leave a fixed-latency pipeline tagged with the source requester ID. The block sits between generated per-channel fixed-point producers and a single downstream consumer, replacing NREQ dedicated format-match instances.

Parameters:
NREQ, 4, number of requesters (2..16)
IW, 13, input word width, signed
IF, 8, input fractional bits
OW, 14, output word width, signed
OF, 8, output fractional bits
LAT, 3, pipeline latency in cycles from accepted request to o_valid (>=1)
RND, 1, 1 = round-half-up on dropped LSBs, 0 = truncate (floor)
SAT, 1, 1 = saturate on overflow, 0 = wrap (keep low OW bits)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
i_valid  in  NREQ  per-requester request valid
i_data  in  NREQ*IW  packed requester words, requester k at [k*IW +: IW]
o_ready  out  NREQ  one-hot grant; requester k transfers when i_valid[k] & o_ready[k]
i_stall  in  1  downstream hold; freezes the pipeline and all grants
o_valid  out  1  result valid
o_data  out  OW  format-matched result
o_id  out  max(1,$clog2(NREQ))  requester index of o_data
o_ovf  out  1  overflow was detected on this result (independent of SAT)

Behaviour:
- Reset: o_valid=0, o_data=0, o_id=0, o_ovf=0, pipeline valid bits cleared, RR pointer=0. Reset mid-operation discards all in-flight results; no result appears for them.
- Grant: combinational. When i_stall=1 or no i_valid: o_ready=0. Otherwise grant the first set i_valid[k] scanning k = ptr, ptr+1, ... mod NREQ. At most one grant per cycle.
- Pointer: on a transfer from k, ptr <= (k+1) mod NREQ. No transfer leaves ptr unchanged. Wrap from NREQ-1 to 0.
- Throughput: one transfer per cycle when not stalled. A requester held continuously valid alone is granted every cycle. With all requesters valid, order is 0,1,...,NREQ-1,0,...
- Pipeline: stage 0 registers the selected word and ID. Quantization and overflow are spread over the remaining stages. A result enters o_* exactly LAT unstalled cycles after transfer. A bubble (no transfer) propagates as o_valid=0.
- Stall: while i_stall=1 every stage, including the o_* registers, holds its value. o_valid may remain 1 for repeated cycles; the consumer counts one result per i_stall=0 cycle with o_valid=1.
- Quantization: D = IF-OF.
  - D>0, RND=1: q = (x + 2^(D-1)) >>> D.
  - D>0, RND=0: q = x >>> D.
  - D<=0: q = x << -D.
  - Intermediate width IW+1+max(0,-D). The rounding carry is never lost.
- Overflow: if q is outside [-2^(OW-1), 2^(OW-1)-1], o_ovf=1. SAT=1 clamps to the nearest bound. SAT=0 keeps q[OW-1:0]. If q fits, it is sign-extended to OW bits and o_ovf=0.
- o_data, o_id and o_ovf are registered outputs. No combinational path from i_data to o_data.

Optional Feature:
FX_MATCH_OVF_CNT_EN:
- Defined: adds outputs o_ovf_cnt [NREQ*16], with one 16-bit saturating counter per requester, and input i_ovf_clr.
  - Counter k increments when a result with o_id=k and o_ovf=1 is presented while i_stall=0.
  - The counter sticks at 16'hFFFF.
  - i_ovf_clr=1 or rst zeroes all counters. Clear wins over a simultaneous increment.
- Undefined: ports and logic absent; o_ovf is still produced.

Decomposition:
- Package fx_match_pkg:
  - Localparam function for ID width.
  - Rounding-mode and overflow-mode constants (RND_TRUNC/RND_HALF_UP, OVF_WRAP/OVF_SAT).
  - Helper function for the saturation bounds for a given OW.
- Sub-module fx_match_core: the parameterised quantize+overflow pipeline, carrying ID and valid alongside the data, with a stall input.
- The top module holds the RR arbiter and the optional counters.

Test Plan:
- Reset mid-run: start the all-valid stream, assert rst for 1 cycle while results are in flight -> o_valid=0 afterwards until new transfers; first grant goes to requester 0.
- Identity format (IF=OF=8, IW=13, OW=14): requester 2 sends 13'h1FFF (-1) -> 3 cycles later o_data=14'h3FFF, o_id=2, o_ovf=0.
- Rounding (IF=8, OF=6, RND=1): x=13'h0006 -> o_data=2. x=13'h0005 -> 1. x=13'h1FFE (-2) -> 0 (half-up toward +inf). With RND=0, x=13'h0007 -> 1.
- Saturation (IF=4, OF=8, OW=14, SAT=1): x=13'h0FFF -> o_data=14'h1FFF, o_ovf=1. Same stimulus with SAT=0 -> o_data=14'h3FF0, o_ovf=1.
- Fairness: all four valid for 8 cycles -> o_id sequence 0,1,2,3,0,1,2,3. Then only requester 3 valid -> granted every cycle, ptr wraps to 0.
- Stall: assert i_stall for 5 cycles with the pipeline full -> o_ready=0 and all outputs frozen. On release, results resume in order with none lost or duplicated.
